lfsr_rng_arbiter: RTL and testbench

- Shares one 16-bit Fibonacci LFSR between NREQ requesters using round-robin arbitration.
- Each grant shifts the LFSR WORD_W times and returns the collected bits as one WORD_W-bit random word, with a one-cycle valid strobe.
- Also controls seeding: loads a runtime seed, blocks the all-zero lockup state, and rejects seed writes while a word is being produced.
- Sits between the random-source datapath and the blocks that consume random words.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr16_core.sv | 48 ++++
 rtl/lfsr_rng_arbiter.sv | 148 ++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and types for the LFSR random-word arbiter
// Purpose: feedback tap positions, default seed and arbiter state encoding.
// Ports: none (package).
package lfsr_pkg;

   // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 (bit indices of the state).
   localparam int TAP_0 = 15;
   localparam int TAP_1 = 13;
   localparam int TAP_2 = 12;
   localparam int TAP_3 = 10;

   localparam logic [15:0] DEFAULT_SEED = 16'hA1C1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} arb_state_t;

endpackage

// File: rtl/lfsr16_core.sv
// rtl/lfsr16_core.sv - 16-bit Fibonacci LFSR with seed load and zero-seed guard
// Purpose: holds the shared random-source state; steps when en=1, loads on load=1.
// Ports:
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous active-low reset (state returns to INIT)
//   en         in   advance the LFSR one step this cycle
//   load       in   load seed (takes priority over en)
//   seed[15:0] in   seed value; zero is replaced by INIT to avoid lockup
//   state[15:0] out current LFSR state; state[15] is the next emitted bit
module lfsr16_core
   import lfsr_pkg::*;
#(
   parameter logic [15:0] INIT = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] seed,
   output logic [15:0] state
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic        fb;

   always_comb begin
      fb      = state_q[TAP_0] ^ state_q[TAP_1] ^ state_q[TAP_2] ^ state_q[TAP_3];
      state_d = state_q;
      if (load) begin
         // All-zero is the lockup state of an XOR LFSR; substitute the default.
         state_d = (seed == 16'h0000) ? INIT : seed;
      end else if (en) begin
         state_d = {state_q[14:0], fb};
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// rtl/lfsr_rng_arbiter.sv - round-robin arbiter sharing one LFSR between requesters
// Purpose: grants one requester at a time, shifts WORD_W LFSR bits into a word and
//          delivers it with a one-cycle rvalid strobe; also handles runtime seeding.
// Ports:
//   clk                in   system clock, rising edge
//   nrst               in   asynchronous active-low reset
//   seed_load          in   load seed_val into the LFSR (honoured only when idle)
//   seed_val[15:0]     in   seed value
//   seed_err           out  one-cycle pulse: a seed_load arrived while busy
//   req[NREQ-1:0]      in   level request per requester
//   gnt[NREQ-1:0]      out  one-hot grant, held from SHIFT through DONE
//   rdata[WORD_W-1:0]  out  random word, valid while rvalid=1 (zero otherwise)
//   rvalid             out  one-cycle strobe in DONE
//   busy               out  high in SHIFT and DONE
module lfsr_rng_arbiter
   import lfsr_pkg::*;
#(
   parameter int          NREQ   = 3,
   parameter int          WORD_W = 8,
   parameter logic [15:0] INIT   = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              seed_load,
   input  logic [15:0]       seed_val,
   output logic              seed_err,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   output logic [WORD_W-1:0] rdata,
   output logic              rvalid,
   output logic              busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = 5;

   arb_state_t        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [PTR_W-1:0]  idx_q, idx_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] w_q, w_d;
   logic              seed_err_q, seed_err_d;

   logic [15:0]       lfsr_state;
   logic              lfsr_en;
   logic              lfsr_load;
   logic [WORD_W:0]   w_ext;
   logic              pick_found;
   logic [PTR_W-1:0]  pick_idx;
   logic [PTR_W:0]    cand;

   assign lfsr_en   = (state_q == SHIFT);
   assign lfsr_load = seed_load && (state_q == IDLE);

   lfsr16_core #(.INIT(INIT)) u_core (
      .clk   (clk),
      .nrst  (nrst),
      .en    (lfsr_en),
      .load  (lfsr_load),
      .seed  (seed_val),
      .state (lfsr_state)
   );

   // Round-robin search: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
         if (cand >= (PTR_W+1)'(NREQ)) begin
            cand = cand - (PTR_W+1)'(NREQ);
         end
         if (!pick_found && req[cand[PTR_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[PTR_W-1:0];
         end
      end
   end

   // MSB-first assembly: the bit about to leave the LFSR enters at the bottom.
   assign w_ext = {w_q, lfsr_state[15]};

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      idx_d      = idx_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      w_d        = w_q;
      seed_err_d = seed_load && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            // A seed load owns the cycle; pending requests are served next cycle.
            if (!seed_load && pick_found) begin
               gnt_d   = NREQ'(1) << pick_idx;
               idx_d   = pick_idx;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            w_d   = w_ext[WORD_W-1:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            rr_ptr_d = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            gnt_d    = '0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         idx_q      <= '0;
         rr_ptr_q   <= '0;
         cnt_q      <= '0;
         w_q        <= '0;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         idx_q      <= idx_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         w_q        <= w_d;
         seed_err_q <= seed_err_d;
      end
   end

   assign gnt      = gnt_q;
   assign busy     = (state_q != IDLE);
   assign rvalid   = (state_q == DONE);
   assign rdata    = rvalid ? w_q : '0;
   assign seed_err = seed_err_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb/tb_lfsr_rng_arbiter.sv - self-checking bench for lfsr_rng_arbiter
module tb_lfsr_rng_arbiter;

   localparam int          NREQ   = 3;
   localparam int          WORD_W = 4;
   localparam logic [15:0] INIT   = 16'hA1C1;

   logic              clk;
   logic              nrst;
   logic              seed_load;
   logic [15:0]       seed_val;
   logic              seed_err;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   gnt;
   logic [WORD_W-1:0] rdata;
   logic              rvalid;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] m_lfsr;
   int          m_ptr;

   lfsr_rng_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .INIT(INIT)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .seed_load (seed_load),
      .seed_val  (seed_val),
      .seed_err  (seed_err),
      .req       (req),
      .gnt       (gnt),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] seed;
      logic [2:0]  r;
      logic [2:0]  exp_gnt;
      logic [3:0]  exp_word;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: parity of tapped bits feeds in at the bottom of a left shift.
   function automatic logic [15:0] m_next(input logic [15:0] s);
      return (s << 1) | {15'd0, ^(s & 16'hB400)};
   endfunction

   task automatic m_word(output logic [3:0] w);
      int acc;
      acc = 0;
      for (int k = 0; k < WORD_W; k++) begin
         acc    = acc * 2 + int'(m_lfsr >> 15);
         m_lfsr = m_next(m_lfsr);
      end
      w = 4'(acc);
   endtask

   function automatic int m_pick(input logic [2:0] r);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
      end
      return 0;
   endfunction

   task automatic do_reset();
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      nrst   = 1'b1;
      m_lfsr = INIT;
      m_ptr  = 0;
      @(negedge clk);
   endtask

   task automatic do_seed(input logic [15:0] s);
      seed_load = 1'b1;
      seed_val  = s;
      @(negedge clk);
      seed_load = 1'b0;
      m_lfsr    = (s == 16'h0) ? INIT : s;
   endtask

   task automatic do_txn(input logic [2:0] r, input bit drop);
      int         idx;
      int         cyc;
      logic [3:0] ew;
      idx = m_pick(r);
      m_word(ew);
      req = r;
      @(negedge clk);
      chk("gnt_rise", 32'(gnt), 32'(1) << idx);
      chk("busy_shift", 32'(busy), 1);
      if (drop) req = '0;
      cyc = 1;
      while (!rvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("rvalid_latency", cyc, WORD_W + 1);
      chk("rdata", 32'(rdata), 32'(ew));
      chk("gnt_at_rvalid", 32'(gnt), 32'(1) << idx);
      req   = '0;
      m_ptr = (idx + 1) % NREQ;
      @(negedge clk);
      chk("rvalid_one_cycle", 32'(rvalid), 0);
      chk("busy_back_idle", 32'(busy), 0);
   endtask

   initial begin
      int         idx;
      int         cyc;
      int         nval;
      logic [3:0] ew;

      nrst      = 1'b0;
      seed_load = 1'b0;
      seed_val  = '0;
      req       = '0;
      m_lfsr    = INIT;
      m_ptr     = 0;

      vecs[0] = '{16'h0000, 3'b001, 3'b001, 4'hA};
      vecs[1] = '{16'h1234, 3'b001, 3'b001, 4'h1};
      vecs[2] = '{16'hFFFF, 3'b101, 3'b100, 4'hF};
      vecs[3] = '{16'h8001, 3'b110, 3'b010, 4'h8};
      vecs[4] = '{16'h5A5A, 3'b011, 3'b001, 4'h5};
      vecs[5] = '{16'hC3C3, 3'b111, 3'b010, 4'hC};
      vecs[6] = '{16'h0001, 3'b111, 3'b100, 4'h0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_seed_err", 32'(seed_err), 0);
      chk("rst_lfsr", 32'(dut.lfsr_state), 32'hA1C1);
      nrst = 1'b1;
      @(negedge clk);

      // First word after reset
      do_txn(3'b001, 1'b0);
      chk("lfsr_after_first", 32'(dut.lfsr_state), 32'h1C11);

      // Zero seed replaced by the default
      do_seed(16'h0000);
      chk("zero_seed_lfsr", 32'(dut.lfsr_state), 32'hA1C1);
      do_txn(3'b001, 1'b0);

      // All requests held: rotation and spacing
      do_reset();
      req = 3'b111;
      for (int t = 0; t < 6; t++) begin
         idx = m_pick(3'b111);
         m_word(ew);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!rvalid && cyc < 30);
         chk("held_spacing", cyc, (t == 0) ? WORD_W + 1 : WORD_W + 2);
         chk("held_gnt", 32'(gnt), 32'(1) << idx);
         chk("held_rdata", 32'(rdata), 32'(ew));
         m_ptr = (idx + 1) % NREQ;
      end
      req = '0;
      @(negedge clk);

      // Seed load while shifting is rejected and leaves the sequence alone
      idx = m_pick(3'b001);
      m_word(ew);
      req = 3'b001;
      @(negedge clk);
      seed_load = 1'b1;
      seed_val  = 16'h0F0F;
      @(negedge clk);
      chk("seed_err_pulse", 32'(seed_err), 1);
      seed_load = 1'b0;
      @(negedge clk);
      chk("seed_err_clear", 32'(seed_err), 0);
      cyc = 3;
      while (!rvalid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("busy_seed_latency", cyc, WORD_W + 1);
      chk("busy_seed_rdata", 32'(rdata), 32'(ew));
      req   = '0;
      m_ptr = (idx + 1) % NREQ;
      @(negedge clk);
      do_txn(3'b001, 1'b0);

      // Seed and request together: seed wins this cycle
      seed_load = 1'b1;
      seed_val  = 16'h7777;
      req       = 3'b010;
      @(negedge clk);
      chk("seed_prio_gnt", 32'(gnt), 0);
      chk("seed_prio_busy", 32'(busy), 0);
      seed_load = 1'b0;
      m_lfsr    = 16'h7777;
      do_txn(3'b010, 1'b0);

      // Table: seed, then one transaction, from a fresh reset
      do_reset();
      for (int v = 0; v < 7; v++) begin
         seed_load = 1'b1;
         seed_val  = vecs[v].seed;
         @(negedge clk);
         seed_load = 1'b0;
         req       = vecs[v].r;
         @(negedge clk);
         chk("tbl_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
         cyc = 1;
         while (!rvalid && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         chk("tbl_word", 32'(rdata), 32'(vecs[v].exp_word));
         req = '0;
         @(negedge clk);
      end

      // Reset in the middle of SHIFT
      do_reset();
      req = 3'b001;
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("abort_gnt", 32'(gnt), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rvalid", 32'(rvalid), 0);
      req = '0;
      @(negedge clk);
      nrst   = 1'b1;
      m_lfsr = INIT;
      m_ptr  = 0;
      nval   = 0;
      repeat (8) begin
         @(negedge clk);
         if (rvalid) nval++;
      end
      chk("abort_no_rvalid", nval, 0);
      do_txn(3'b001, 1'b0);

      // Randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            do_seed(($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom));
         end
         do_txn(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
